// File: rtl/udp_tx_stream_gen_pkg.sv
// Shared types and constants for the UDP transmit stream generator.
// The payload pattern is a rolling byte counter that starts at the request seed.
package udp_tx_stream_gen_pkg;

  localparam int DATA_WIDTH     = 256;
  localparam int KEEP_WIDTH     = 32;
  localparam int BYTES_PER_BEAT = 32;
  localparam int IP_ADDR_WIDTH  = 32;
  localparam int UDP_PORT_WIDTH = 16;
  localparam int UDP_LEN_WIDTH  = 16;
  // ceil(65535/32) = 2048 beats, so beat indices need 12 bits
  localparam int BEAT_IDX_WIDTH = 12;

  typedef struct packed {
    logic [UDP_LEN_WIDTH-1:0]  data_len;
    logic [IP_ADDR_WIDTH-1:0]  ip_addr;
    logic [UDP_PORT_WIDTH-1:0] dst_port;
    logic [UDP_PORT_WIDTH-1:0] src_port;
  } udp_meta_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tfirst;
    logic                  tlast;
  } ds_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_META = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Byte 32*b + lane of the packet; only beat[2:0] matters modulo 256.
  function automatic logic [7:0] pattern_byte(input logic [7:0] seed,
                                              input logic [2:0] beat_lsb,
                                              input logic [4:0] lane);
    return seed + {beat_lsb, 5'b00000} + {3'b000, lane};
  endfunction

endpackage

// File: rtl/udp_payload_beat_gen.sv
// Combinational payload beat builder: pattern bytes, byte enables and framing
// for one beat index of a packet.
module udp_payload_beat_gen
  import udp_tx_stream_gen_pkg::*;
(
  input  logic [7:0]                seed,
  input  logic [BEAT_IDX_WIDTH-1:0] beat_idx,
  input  logic [BEAT_IDX_WIDTH-1:0] beats,
  input  logic [4:0]                rem,
  output ds_beat_t                  beat
);

  logic keep_bit;

  always_comb begin
    beat     = '0;
    keep_bit = 1'b0;
    beat.tfirst = (beat_idx == '0);
    beat.tlast  = (beat_idx == (beats - BEAT_IDX_WIDTH'(1)));
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      // A zero remainder means the last beat is completely full.
      keep_bit = !beat.tlast || (rem == 5'd0) || (5'(k) < rem);
      beat.tkeep[k] = keep_bit;
      beat.tdata[8*k +: 8] = keep_bit ? pattern_byte(seed, beat_idx[2:0], 5'(k)) : 8'h00;
    end
  end

endmodule

// File: rtl/udp_tx_stream_gen.sv
// UDP transmit traffic source: accepts a request, emits one metadata beat,
// then the patterned payload as first/last-framed stream beats.
module udp_tx_stream_gen
  import udp_tx_stream_gen_pkg::*;
#(
  parameter int DATA_WIDTH     = udp_tx_stream_gen_pkg::DATA_WIDTH,
  parameter int KEEP_WIDTH     = udp_tx_stream_gen_pkg::KEEP_WIDTH,
  parameter int IP_ADDR_WIDTH  = udp_tx_stream_gen_pkg::IP_ADDR_WIDTH,
  parameter int UDP_PORT_WIDTH = udp_tx_stream_gen_pkg::UDP_PORT_WIDTH,
  parameter int UDP_LEN_WIDTH  = udp_tx_stream_gen_pkg::UDP_LEN_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_req_valid,
  output logic                      s_req_ready,
  input  logic [IP_ADDR_WIDTH-1:0]  s_req_ip_addr,
  input  logic [UDP_PORT_WIDTH-1:0] s_req_dst_port,
  input  logic [UDP_PORT_WIDTH-1:0] s_req_src_port,
  input  logic [UDP_LEN_WIDTH-1:0]  s_req_data_len,
  input  logic [7:0]                s_req_seed,
  output logic                      m_udp_meta_valid,
  input  logic                      m_udp_meta_ready,
  output logic [IP_ADDR_WIDTH-1:0]  m_udp_meta_ip_addr,
  output logic [UDP_PORT_WIDTH-1:0] m_udp_meta_dst_port,
  output logic [UDP_PORT_WIDTH-1:0] m_udp_meta_src_port,
  output logic [UDP_LEN_WIDTH-1:0]  m_udp_meta_data_len,
  output logic                      m_data_stream_tvalid,
  input  logic                      m_data_stream_tready,
  output logic [DATA_WIDTH-1:0]     m_data_stream_tdata,
  output logic [KEEP_WIDTH-1:0]     m_data_stream_tkeep,
  output logic                      m_data_stream_tfirst,
  output logic                      m_data_stream_tlast,
  output logic                      busy,
  output logic                      zero_len_drop,
  output logic [31:0]               pkt_count,
  output state_t                    fsm_state
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both 1; once valid is raised it and its payload stay
  // unchanged until that edge. All valids and readies here come from flops.

  state_t                    state_q;
  udp_meta_t                 meta_q;
  ds_beat_t                  beat_q;
  ds_beat_t                  next_beat;
  logic [7:0]                seed_q;
  logic [BEAT_IDX_WIDTH-1:0] beats_q;
  logic [BEAT_IDX_WIDTH-1:0] beat_idx_q;
  logic [BEAT_IDX_WIDTH-1:0] next_idx;
  logic [4:0]                rem_q;
  logic [16:0]               len_round;
  logic                      req_ready_q;
  logic                      meta_valid_q;
  logic                      tvalid_q;
  logic                      busy_q;
  logic                      drop_q;
  logic [31:0]               pkt_count_q;

  // 17-bit sum keeps len=0xFFFF from wrapping before the divide by 32.
  assign len_round = {1'b0, s_req_data_len} + 17'd31;

  // Beat to be registered next: beat 0 out of META, otherwise the following one.
  assign next_idx = (state_q == ST_META) ? '0 : (beat_idx_q + BEAT_IDX_WIDTH'(1));

  udp_payload_beat_gen u_beat_gen (
    .seed     (seed_q),
    .beat_idx (next_idx),
    .beats    (beats_q),
    .rem      (rem_q),
    .beat     (next_beat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      meta_q       <= '0;
      beat_q       <= '0;
      seed_q       <= '0;
      beats_q      <= '0;
      beat_idx_q   <= '0;
      rem_q        <= '0;
      req_ready_q  <= 1'b0;
      meta_valid_q <= 1'b0;
      tvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (s_req_valid && req_ready_q) begin
            if (s_req_data_len == '0) begin
              drop_q <= 1'b1;
            end else begin
              meta_q.data_len <= s_req_data_len;
              meta_q.ip_addr  <= s_req_ip_addr;
              meta_q.dst_port <= s_req_dst_port;
              meta_q.src_port <= s_req_src_port;
              seed_q          <= s_req_seed;
              beats_q         <= len_round[16:5];
              rem_q           <= s_req_data_len[4:0];
              req_ready_q     <= 1'b0;
              meta_valid_q    <= 1'b1;
              busy_q          <= 1'b1;
              state_q         <= ST_META;
            end
          end
        end
        ST_META: begin
          if (meta_valid_q && m_udp_meta_ready) begin
            meta_valid_q <= 1'b0;
            beat_idx_q   <= '0;
            beat_q       <= next_beat;
            tvalid_q     <= 1'b1;
            state_q      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tvalid_q && m_data_stream_tready) begin
            if (beat_q.tlast) begin
              tvalid_q    <= 1'b0;
              busy_q      <= 1'b0;
              req_ready_q <= 1'b1;
              pkt_count_q <= pkt_count_q + 32'd1;
              state_q     <= ST_IDLE;
            end else begin
              beat_idx_q <= next_idx;
              beat_q     <= next_beat;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_req_ready          = req_ready_q;
  assign m_udp_meta_valid     = meta_valid_q;
  assign m_udp_meta_ip_addr   = meta_q.ip_addr;
  assign m_udp_meta_dst_port  = meta_q.dst_port;
  assign m_udp_meta_src_port  = meta_q.src_port;
  assign m_udp_meta_data_len  = meta_q.data_len;
  assign m_data_stream_tvalid = tvalid_q;
  assign m_data_stream_tdata  = beat_q.tdata;
  assign m_data_stream_tkeep  = beat_q.tkeep;
  assign m_data_stream_tfirst = beat_q.tfirst;
  assign m_data_stream_tlast  = beat_q.tlast;
  assign busy                 = busy_q;
  assign zero_len_drop        = drop_q;
  assign pkt_count            = pkt_count_q;
  assign fsm_state            = state_q;

endmodule

// File: tb/tb_udp_tx_stream_gen.sv
// Bench for udp_tx_stream_gen: a packet-level model builds expected meta and
// beat lists from each request; one negedge process compares every cycle.
module tb_udp_tx_stream_gen;
  import udp_tx_stream_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic [31:0] s_req_ip_addr = '0;
  logic [15:0] s_req_dst_port = '0;
  logic [15:0] s_req_src_port = '0;
  logic [15:0] s_req_data_len = '0;
  logic [7:0]  s_req_seed = '0;
  logic        m_udp_meta_valid;
  logic        m_udp_meta_ready = 1'b1;
  logic [31:0] m_udp_meta_ip_addr;
  logic [15:0] m_udp_meta_dst_port;
  logic [15:0] m_udp_meta_src_port;
  logic [15:0] m_udp_meta_data_len;
  logic        m_data_stream_tvalid;
  logic        m_data_stream_tready = 1'b1;
  logic [255:0] m_data_stream_tdata;
  logic [31:0] m_data_stream_tkeep;
  logic        m_data_stream_tfirst;
  logic        m_data_stream_tlast;
  logic        busy;
  logic        zero_len_drop;
  logic [31:0] pkt_count;
  state_t      fsm_state;

  udp_tx_stream_gen dut (
    .clk(clk), .reset(reset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_ip_addr(s_req_ip_addr), .s_req_dst_port(s_req_dst_port),
    .s_req_src_port(s_req_src_port), .s_req_data_len(s_req_data_len),
    .s_req_seed(s_req_seed),
    .m_udp_meta_valid(m_udp_meta_valid), .m_udp_meta_ready(m_udp_meta_ready),
    .m_udp_meta_ip_addr(m_udp_meta_ip_addr), .m_udp_meta_dst_port(m_udp_meta_dst_port),
    .m_udp_meta_src_port(m_udp_meta_src_port), .m_udp_meta_data_len(m_udp_meta_data_len),
    .m_data_stream_tvalid(m_data_stream_tvalid), .m_data_stream_tready(m_data_stream_tready),
    .m_data_stream_tdata(m_data_stream_tdata), .m_data_stream_tkeep(m_data_stream_tkeep),
    .m_data_stream_tfirst(m_data_stream_tfirst), .m_data_stream_tlast(m_data_stream_tlast),
    .busy(busy), .zero_len_drop(zero_len_drop), .pkt_count(pkt_count),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [79:0]  exp_meta_q[$];
  logic [289:0] exp_q[$];     // {tdata, tkeep, tfirst, tlast}
  logic [289:0] cap_q[$];     // accepted DUT beats, for literal checks
  logic [31:0]  exp_pkt = '0;
  logic         exp_drop = 1'b0;
  logic         check_en = 1'b0;
  logic         rand_ready = 1'b0;

  task automatic chk(input string name, input logic [289:0] act, input logic [289:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Packet-level model: expand the request into its byte list, then slice.
  task automatic push_model(input logic [15:0] len, input logic [7:0] seed,
                            input logic [31:0] ip, input logic [15:0] dst,
                            input logic [15:0] src);
    int n;
    logic [255:0] d;
    logic [31:0]  k;
    if (len == 16'd0) begin
      exp_drop = 1'b1;
      return;
    end
    exp_meta_q.push_back({len, ip, dst, src});
    n = (int'(len) + 31) / 32;
    for (int b = 0; b < n; b++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 32; j++) begin
        if (32*b + j < int'(len)) begin
          d[8*j +: 8] = 8'(int'(seed) + 32*b + j);
          k[j] = 1'b1;
        end
      end
      exp_q.push_back({d, k, (b == 0), (b == n-1)});
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en && !reset) begin
      chk("busy", busy, (exp_meta_q.size() != 0) || (exp_q.size() != 0));
      chk("req_ready", s_req_ready, (exp_meta_q.size() == 0) && (exp_q.size() == 0));
      chk("zero_len_drop", zero_len_drop, exp_drop);
      exp_drop = 1'b0;
      chk("pkt_count", pkt_count, exp_pkt);
      chk("meta_data_exclusive", m_udp_meta_valid && m_data_stream_tvalid, 1'b0);
      if (m_udp_meta_valid) begin
        if (exp_meta_q.size() == 0) begin
          chk("meta_unexpected", 1'b1, 1'b0);
        end else begin
          chk("meta_fields", {m_udp_meta_data_len, m_udp_meta_ip_addr,
                              m_udp_meta_dst_port, m_udp_meta_src_port}, exp_meta_q[0]);
          if (m_udp_meta_ready) void'(exp_meta_q.pop_front());
        end
      end
      if (m_data_stream_tvalid) begin
        if (exp_q.size() == 0 || exp_meta_q.size() != 0) begin
          chk("beat_unexpected", 1'b1, 1'b0);
        end else begin
          chk("beat", {m_data_stream_tdata, m_data_stream_tkeep,
                       m_data_stream_tfirst, m_data_stream_tlast}, exp_q[0]);
          if (m_data_stream_tready) begin
            cap_q.push_back({m_data_stream_tdata, m_data_stream_tkeep,
                             m_data_stream_tfirst, m_data_stream_tlast});
            if (exp_q[0][0]) exp_pkt = exp_pkt + 32'd1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- sink ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) begin
        m_udp_meta_ready     = 1'($urandom_range(0, 1));
        m_data_stream_tready = 1'($urandom_range(0, 1));
      end else begin
        m_udp_meta_ready     = 1'b1;
        m_data_stream_tready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [15:0] len, input logic [7:0] seed,
                          input logic [31:0] ip, input logic [15:0] dst,
                          input logic [15:0] src);
    int n = 0;
    @(negedge clk);
    while (!s_req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!s_req_ready) begin
      chk("req_ready_timeout", 1'b0, 1'b1);
      return;
    end
    s_req_valid    = 1'b1;
    s_req_data_len = len;
    s_req_seed     = seed;
    s_req_ip_addr  = ip;
    s_req_dst_port = dst;
    s_req_src_port = src;
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    push_model(len, seed, ip, dst, src);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_meta_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_meta_q.size() != 0 || exp_q.size() != 0) chk("drain_timeout", 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic do_reset_release();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_low_at_release", s_req_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("ready_first_cycle", s_req_ready, 1'b1);
    check_en = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", s_req_ready, 1'b0);
    chk("rst_valids", {m_udp_meta_valid, m_data_stream_tvalid, busy, zero_len_drop}, 4'b0);
    chk("rst_pkt_count", pkt_count, 32'd0);
    chk("rst_data", {m_data_stream_tdata, m_data_stream_tkeep}, 288'd0);
    do_reset_release();

    // len=64, seed 0: two full beats
    cap_q.delete();
    send_req(16'd64, 8'h00, 32'hC0A8_0001, 16'd1234, 16'd5678);
    wait_idle();
    chk("t1_nbeats", cap_q.size(), 2);
    chk("t1_beat0", cap_q[0],
        {256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100,
         32'hFFFF_FFFF, 1'b1, 1'b0});
    chk("t1_beat1_hi", cap_q[1][289:282], 8'h3F);
    chk("t1_beat1_lo", cap_q[1][41:34], 8'h20);
    chk("t1_beat1_frame", {cap_q[1][33:0]}, {32'hFFFF_FFFF, 1'b0, 1'b1});
    chk("t1_pkt_count", pkt_count, 32'd1);

    // len=33, seed 0xF0: second beat carries one byte 0x10
    cap_q.delete();
    send_req(16'd33, 8'hF0, 32'h0A00_0002, 16'd80, 16'd4000);
    wait_idle();
    chk("t2_nbeats", cap_q.size(), 2);
    chk("t2_beat0_lane0", cap_q[0][41:34], 8'hF0);
    chk("t2_beat1", cap_q[1], {256'h10, 32'h0000_0001, 1'b0, 1'b1});

    // len=1, seed 0xAB: single beat with both framing bits
    cap_q.delete();
    send_req(16'd1, 8'hAB, 32'h0A00_0003, 16'd1, 16'd2);
    wait_idle();
    chk("t3_nbeats", cap_q.size(), 1);
    chk("t3_beat", cap_q[0], {256'hAB, 32'h1, 1'b1, 1'b1});

    // len=0: dropped, nothing emitted
    send_req(16'd0, 8'h55, 32'h0A00_0004, 16'd3, 16'd4);
    repeat (4) @(negedge clk);
    chk("t4_pkt_count", pkt_count, 32'd3);
    chk("t4_ready", s_req_ready, 1'b1);

    // len=100 under random backpressure
    rand_ready = 1'b1;
    cap_q.delete();
    send_req(16'd100, 8'h00, 32'h0A00_0005, 16'd9, 16'd10);
    wait_idle();
    rand_ready = 1'b0;
    chk("t5_nbeats", cap_q.size(), 4);
    chk("t5_last", cap_q[3], {256'h63626160, 32'h0000_000F, 1'b0, 1'b1});
    chk("t5_pkt_count", pkt_count, 32'd4);

    // randomized requests, back-to-back, random backpressure
    rand_ready = 1'b1;
    for (int r = 0; r < 30; r++) begin
      send_req(16'($urandom_range(0, 200)), 8'($urandom), $urandom,
               16'($urandom), 16'($urandom));
    end
    wait_idle();
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset after beat 1 of a 4-beat packet
    send_req(16'd128, 8'h11, 32'h0A00_0006, 16'd7, 16'd8);
    begin
      int n = 0;
      while (exp_q.size() > 2 && n < 200) begin
        @(posedge clk);
        n++;
      end
      if (exp_q.size() > 2) chk("t6_progress_timeout", 1'b0, 1'b1);
    end
    #3;
    check_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_valids_drop", {m_udp_meta_valid, m_data_stream_tvalid, busy}, 3'b0);
    chk("t6_pkt_cleared", pkt_count, 32'd0);
    exp_meta_q.delete();
    exp_q.delete();
    exp_pkt = '0;
    exp_drop = 1'b0;
    repeat (2) @(posedge clk);
    do_reset_release();
    cap_q.delete();
    send_req(16'd32, 8'h40, 32'h0A00_0007, 16'd11, 16'd12);
    wait_idle();
    chk("t6_nbeats", cap_q.size(), 1);
    chk("t6_frame", cap_q[0][33:0], {32'hFFFF_FFFF, 1'b1, 1'b1});
    chk("t6_pkt_count", pkt_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_stream_gen.md
# udp_tx_stream_gen

- Generates complete UDP transmit transactions: UDP metadata plus a patterned payload stream.
- Drives the Tx side of the UDP/ARP/Ethernet stack, i.e. the `s_udp_meta_*` and `s_data_stream_*` inputs.
- Takes one request (destination, ports, length, pattern seed) and emits one metadata beat, then the payload as first/last-framed DataStream beats.
- Used as a traffic source for loopback and throughput testing.

## Interface
Parameters:
- DATA_WIDTH, 256, payload beat width in bits
- KEEP_WIDTH, 32, byte enables per beat (DATA_WIDTH/8)
- IP_ADDR_WIDTH, 32, IPv4 address width
- UDP_PORT_WIDTH, 16, UDP port width
- UDP_LEN_WIDTH, 16, payload length width, in bytes

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- s_req_valid / s_req_ready  in/out  1  request handshake
- s_req_ip_addr  in  IP_ADDR_WIDTH  destination IP
- s_req_dst_port / s_req_src_port  in  UDP_PORT_WIDTH  UDP ports
- s_req_data_len  in  UDP_LEN_WIDTH  payload bytes
- s_req_seed  in  8  first payload byte value
- m_udp_meta_valid / m_udp_meta_ready  out/in  1  metadata handshake
- m_udp_meta_ip_addr, m_udp_meta_dst_port, m_udp_meta_src_port, m_udp_meta_data_len  out  as request  latched request fields
- m_data_stream_tvalid / m_data_stream_tready  out/in  1  payload handshake
- m_data_stream_tdata  out  DATA_WIDTH  payload bytes
- m_data_stream_tkeep  out  KEEP_WIDTH  byte enables
- m_data_stream_tfirst / m_data_stream_tlast  out  1  packet framing
- busy  out  1  high while not IDLE
- zero_len_drop  out  1  one-cycle pulse when a zero-length request is accepted
- pkt_count  out  32  completed packets; wraps at 2^32

## Operation
- States:
  - IDLE: s_req_ready=1. A request handshake latches all fields, computes beats = (len+31)>>5 in 17-bit arithmetic, and goes to META. A len=0 request goes to IDLE instead, with zero_len_drop pulsed and nothing emitted.
  - META: m_udp_meta_valid=1 until the handshake, then go to DATA.
  - DATA: beat index counts from 0 to beats-1. Each tvalid&tready handshake advances it. The handshake on the last beat returns to IDLE and increments pkt_count.
- Metadata always completes before the first data beat. The two are never concurrent.
- Payload byte i (i counts from 0 across the whole packet) = (seed + i) mod 256.
  - Byte lane k of beat b carries byte 32b+k.
  - Lane 0 sits in tdata[7:0].
- tkeep is all ones except on the last beat, where it has the low r bits set, r = len mod 32 (r=0 means all ones).
- tdata lanes with tkeep=0 are driven to 0.
- tfirst=1 only on beat 0. tlast=1 only on beat beats-1. A single-beat packet has both set.
- Valid-held rule: once asserted, valid and all payload/meta fields stay stable until the handshake.
- Reset values: all valids 0, s_req_ready 0 while reset is asserted and 1 in the first cycle after release, busy 0, zero_len_drop 0, pkt_count 0, data/meta outputs 0.

## Timing
- Request accepted at cycle N → m_udp_meta_valid=1 at N+1.
- Meta handshake at cycle M → first data beat valid at M+1.
- Data beats run back-to-back while tready=1, one beat per cycle.
- Last-beat handshake at cycle T → IDLE and s_req_ready=1 at T+1. pkt_count is updated at T+1.
- Minimum packet period is beats+2 cycles.
- Zero-length request at N → zero_len_drop=1 at N+1, s_req_ready stays 1.
- Reset asserted mid-packet: valids drop immediately (asynchronously) and the partial packet is abandoned, with no tlast issued. The next request starts cleanly with tfirst.
- All outputs are registered. There is no combinational path from any ready input to any valid output.

## Structure
- Shared package holds:
  - width constants (DATA_WIDTH, KEEP_WIDTH, bytes per beat = 32)
  - UDP meta struct {data_len, ip_addr, dst_port, src_port}, in that field order
  - DataStream beat struct {tdata, tkeep, tfirst, tlast}
  - state enum {IDLE, META, DATA}
  - byte-pattern function
- One sub-module: udp_payload_beat_gen. It is combinational; given seed, beat index, beats and remainder, it returns tdata, tkeep, tfirst and tlast.
- The top module holds the FSM, counters and output registers.

## Test plan
- len=64, seed=0x00, ready always 1 → meta then 2 beats.
  - Both beats have tkeep=0xFFFFFFFF.
  - Beat 0 carries bytes 0x00..0x1F; beat 1 carries bytes 0x20..0x3F.
  - tfirst on beat 0, tlast on beat 1; pkt_count=1.
- len=33, seed=0xF0 → 2 beats.
  - Beat 1: tkeep=0x00000001, tdata[7:0]=0x10, all other lanes 0.
- len=1, seed=0xAB → one beat with tfirst=tlast=1, tkeep=0x1, tdata[7:0]=0xAB.
- len=0 → zero_len_drop pulse, no meta or data valid, pkt_count unchanged, s_req_ready stays 1.
- len=100 with random meta/data ready (≈50%) → every field stays stable while valid&!ready.
  - Byte sequence matches the pattern; 4 beats; last tkeep=0x0000000F.
- Reset asserted after beat 1 of a 4-beat packet → valids 0 immediately.
  - After release, a new len=32 request yields exactly one beat with tfirst=1 and tlast=1; pkt_count=1.
